// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-ported RAM between the pipeline's
// instruction and data ports. One transaction in flight at a time, data
// before instruction, with a per-transaction timeout that raises a sticky
// mem_err instead of letting a hung RAM freeze the pipeline.
module pipe_mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DACC = 2'd1,
    S_IACC = 2'd2
  } state_t;

  state_t         r_state;
  logic [31:0]    r_addr;
  logic [31:0]    r_data;
  logic           r_wr;
  logic [CW-1:0]  r_wait;
  logic           r_err;

  // The wait counter sits on its last allowed value: one more miss aborts.
  logic           w_last_wait;
  assign w_last_wait = (r_wait == CW'(TIMEOUT - 1));

  // Arbitration, transaction latching, wait counting and the sticky error.
  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, so ordering inside this block does not matter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // ram_ready is deliberately ignored here; only a strobed access
          // can complete.
          if (dREN || dWEN) begin
            r_state <= S_DACC;
            r_addr  <= daddr;
            r_data  <= dstore;
            r_wr    <= dWEN;  // read+write together resolves to a write
            r_wait  <= '0;
          end else if (iREN && !halt) begin
            r_state <= S_IACC;
            r_addr  <= iaddr;
            r_wr    <= 1'b0;
            r_wait  <= '0;
          end
        end
        S_DACC, S_IACC: begin
          // A completion in the final allowed cycle beats the timeout.
          if (ram_ready) begin
            r_state <= S_IDLE;
          end else if (w_last_wait) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_wait  <= r_wait + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes and hit handshakes decode from state, so an async reset
  // drops them immediately and a hit lasts only for the ready cycle.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    case (r_state)
      S_DACC: begin
        ramaddr = r_addr;
        if (r_wr) begin
          ramWEN   = 1'b1;
          ramstore = r_data;
        end else begin
          ramREN   = 1'b1;
        end
        if (ram_ready) begin
          dhit  = 1'b1;
          dload = ramload;
        end
      end
      S_IACC: begin
        ramREN  = 1'b1;
        ramaddr = r_addr;
        if (ram_ready) begin
          ihit  = 1'b1;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

  assign mem_err = r_err;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter, built with TIMEOUT=8. Inputs change
// 2 time units after each rising edge; outputs are sampled 1 unit later,
// well clear of both edges.
`timescale 1ns/1ps
module tb_pipe_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        halt, iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ramREN, ramWEN, ihit, dhit, mem_err;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_mem_arbiter #(.TIMEOUT(8), .CW(8)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge, ready to drive new inputs.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  // All handshake and strobe outputs low, as in IDLE with no completion.
  task automatic check_quiet(input string tag);
    check({tag, ".ramREN"},  {31'd0, ramREN}, 32'd0);
    check({tag, ".ramWEN"},  {31'd0, ramWEN}, 32'd0);
    check({tag, ".ramaddr"}, ramaddr, 32'd0);
    check({tag, ".ihit"},    {31'd0, ihit},   32'd0);
    check({tag, ".dhit"},    {31'd0, dhit},   32'd0);
  endtask

  initial begin
    nRST = 1'b0; halt = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    ram_ready = 1'b0; iaddr = '0; daddr = '0; dstore = '0; ramload = '0;

    // ---- Reset then idle ----
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check_quiet("rst");
      check("rst.ramstore", ramstore, 32'd0);
      check("rst.iload", iload, 32'd0);
      check("rst.dload", dload, 32'd0);
      check("rst.mem_err", {31'd0, mem_err}, 32'd0);
    end
    nRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      check_quiet("idle");
      check("idle.mem_err", {31'd0, mem_err}, 32'd0);
    end

    // ---- Fetch with RAM latency 2 ----
    iREN = 1'b1; iaddr = 32'h40; settle();          // cycle N, IDLE
    check("f.N.ramREN", {31'd0, ramREN}, 32'd0);
    tick(); iaddr = 32'h999; settle();              // N+1, address change ignored
    check("f.N1.ramREN", {31'd0, ramREN}, 32'd1);
    check("f.N1.ramaddr", ramaddr, 32'h40);
    check("f.N1.ihit", {31'd0, ihit}, 32'd0);
    tick(); settle();                               // N+2, still waiting
    check("f.N2.ramaddr", ramaddr, 32'h40);
    check("f.N2.ihit", {31'd0, ihit}, 32'd0);
    tick(); ram_ready = 1'b1; ramload = 32'h8C220004; settle();  // N+3
    check("f.hit.ihit", {31'd0, ihit}, 32'd1);
    check("f.hit.iload", iload, 32'h8C220004);
    check("f.hit.dhit", {31'd0, dhit}, 32'd0);
    tick(); iREN = 1'b0; ram_ready = 1'b0; settle();
    check_quiet("f.after");
    check("f.after.iload", iload, 32'd0);

    // ---- Simultaneous data write and fetch: data wins ----
    iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    ram_ready = 1'b1; ramload = 32'h0; settle();    // IDLE ignores ram_ready
    check_quiet("sim.idle");
    tick(); settle();                               // DACC write completes
    check("sim.w.ramWEN", {31'd0, ramWEN}, 32'd1);
    check("sim.w.ramREN", {31'd0, ramREN}, 32'd0);
    check("sim.w.ramaddr", ramaddr, 32'h100);
    check("sim.w.ramstore", ramstore, 32'hDEADBEEF);
    check("sim.w.dhit", {31'd0, dhit}, 32'd1);
    check("sim.w.ihit", {31'd0, ihit}, 32'd0);
    tick(); dWEN = 1'b0; settle();                  // separating IDLE
    check_quiet("sim.gap");
    check("sim.gap.ramstore", ramstore, 32'd0);
    tick(); ramload = 32'h11112222; settle();       // IACC fetch of 0x44
    check("sim.f.ramREN", {31'd0, ramREN}, 32'd1);
    check("sim.f.ramaddr", ramaddr, 32'h44);
    check("sim.f.ihit", {31'd0, ihit}, 32'd1);
    check("sim.f.iload", iload, 32'h11112222);
    tick(); iREN = 1'b0; ram_ready = 1'b0; settle();
    check_quiet("sim.after");

    // ---- Halt gating ----
    halt = 1'b1; iREN = 1'b1; iaddr = 32'h60;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("halt.ramREN", {31'd0, ramREN}, 32'd0);
      tick();
    end
    halt = 1'b0; settle();                          // IDLE, accepted at next edge
    check("halt.rel.ramREN", {31'd0, ramREN}, 32'd0);
    tick(); halt = 1'b1; settle();                  // IACC, halt raised
    check("halt.iacc.ramREN", {31'd0, ramREN}, 32'd1);
    check("halt.iacc.ramaddr", ramaddr, 32'h60);
    tick(); ram_ready = 1'b1; ramload = 32'h20010005; settle();
    check("halt.iacc.ihit", {31'd0, ihit}, 32'd1);
    check("halt.iacc.iload", iload, 32'h20010005);
    tick(); iREN = 1'b0; halt = 1'b0; ram_ready = 1'b0; settle();
    check_quiet("halt.after");

    // ---- Ready in the last allowed wait cycle: hit wins, no error ----
    dREN = 1'b1; daddr = 32'h180; settle();         // IDLE
    tick();                                         // DACC, wait=0
    for (int i = 0; i < 7; i++) begin               // wait = 0..6, no ready
      settle();
      check("edge.dhit", {31'd0, dhit}, 32'd0);
      check("edge.ramREN", {31'd0, ramREN}, 32'd1);
      tick();
    end
    ram_ready = 1'b1; ramload = 32'hA5A5A5A5; settle();  // wait = 7
    check("edge.last.dhit", {31'd0, dhit}, 32'd1);
    check("edge.last.dload", dload, 32'hA5A5A5A5);
    tick(); dREN = 1'b0; ram_ready = 1'b0; settle();
    check_quiet("edge.after");
    check("edge.after.mem_err", {31'd0, mem_err}, 32'd0);

    // ---- Timeout: 8 cycles in DACC, no hit, sticky mem_err ----
    dREN = 1'b1; daddr = 32'h200; settle();         // IDLE
    tick();
    for (int i = 0; i < 8; i++) begin               // wait = 0..7
      settle();
      check("to.ramREN", {31'd0, ramREN}, 32'd1);
      check("to.ramaddr", ramaddr, 32'h200);
      check("to.dhit", {31'd0, dhit}, 32'd0);
      check("to.mem_err", {31'd0, mem_err}, 32'd0);
      tick();
    end
    daddr = 32'h204; settle();                      // aborted back to IDLE
    check_quiet("to.idle");
    check("to.idle.mem_err", {31'd0, mem_err}, 32'd1);
    tick(); daddr = 32'h300; settle();              // retry in DACC, addr stable
    check("to.retry.ramaddr", ramaddr, 32'h204);
    check("to.retry.ramREN", {31'd0, ramREN}, 32'd1);
    check("to.retry.dhit", {31'd0, dhit}, 32'd0);
    tick(); ram_ready = 1'b1; ramload = 32'hCAFEF00D; settle();
    check("to.retry.hit", {31'd0, dhit}, 32'd1);
    check("to.retry.dload", dload, 32'hCAFEF00D);
    check("to.retry.addr", ramaddr, 32'h204);
    check("to.retry.mem_err", {31'd0, mem_err}, 32'd1);
    tick(); dREN = 1'b0; ram_ready = 1'b0; settle();
    check_quiet("to.after");
    check("to.after.mem_err", {31'd0, mem_err}, 32'd1);

    // ---- Reset in the middle of a fetch ----
    iREN = 1'b1; iaddr = 32'h80; settle();          // IDLE
    tick(); settle();                               // IACC
    check("mr.ramREN", {31'd0, ramREN}, 32'd1);
    nRST = 1'b0; ram_ready = 1'b1; ramload = 32'h12345678; settle();
    check("mr.async.ramREN", {31'd0, ramREN}, 32'd0);
    check("mr.async.ihit", {31'd0, ihit}, 32'd0);
    check("mr.async.mem_err", {31'd0, mem_err}, 32'd0);
    tick(); settle();                               // still in reset
    check_quiet("mr.held");
    tick(); nRST = 1'b1; ram_ready = 1'b0; settle(); // IDLE, request seen
    check_quiet("mr.rel");
    tick(); settle();                               // IACC again
    check("mr.refetch.ramREN", {31'd0, ramREN}, 32'd1);
    check("mr.refetch.ramaddr", ramaddr, 32'h80);
    check("mr.refetch.ihit", {31'd0, ihit}, 32'd0);
    tick(); ram_ready = 1'b1; ramload = 32'h0BADF00D; settle();
    check("mr.refetch.hit", {31'd0, ihit}, 32'd1);
    check("mr.refetch.iload", iload, 32'h0BADF00D);
    tick(); iREN = 1'b0; ram_ready = 1'b0; settle();
    check_quiet("mr.after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
